// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared definitions for the 7-segment display path.
//   Segment codes are {g,f,e,d,c,b,a}, active-low (0 = segment lit).
//   bcd_to_seg maps a 4-bit BCD digit to its segment code; values A..F
//   show a dash so a corrupted counter value is visible on the display.
package seg7_pkg;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_ALL  = 7'h00;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] code;
        case (bcd)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_DASH;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder
//   Combinational BCD to 7-segment decoder (active-low segment code).
//   Ports:
//     bcd       in  4  BCD digit (A..F decode to a dash)
//     seg_code  out 7  {g,f,e,d,c,b,a}, active-low
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_code
);

    assign seg_code = bcd_to_seg(bcd);

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Multiplexed common-anode 7-segment driver. One digit is driven per
//   refresh slot of REFRESH_DIV clocks; the first BLANK_CYC clocks of each
//   slot keep every anode off to avoid ghosting between digits. The digit
//   values and decimal-point mask are captured once per full scan so a
//   counter update mid-scan never shows a torn value.
//   Ports:
//     clk        in  1        system clock, rising edge
//     rst        in  1        asynchronous reset, active-high
//     din        in  4*N_DIG  packed BCD, digit i = din[4*i+3:4*i]
//     dp_mask    in  N_DIG    1 = decimal point lit on digit i
//     lz_blank   in  1        1 = suppress leading zeros
//     lamp_test  in  1        1 = all segments and dp on during drive phase
//     an         out N_DIG    anode enables, active-low, at most one low
//     seg        out 7        {g,f,e,d,c,b,a}, active-low
//     dp         out 1        decimal point, active-low
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIG       = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_CYC   = 1000
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [4*N_DIG-1:0] din,
    input  logic [N_DIG-1:0]   dp_mask,
    input  logic               lz_blank,
    input  logic               lamp_test,
    output logic [N_DIG-1:0]   an,
    output logic [6:0]         seg,
    output logic               dp
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_V  = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIG - 1);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [4*N_DIG-1:0] snap_q, snap_d;
    logic [N_DIG-1:0]   dpm_q, dpm_d;
    logic               first_q, first_d;
    logic [N_DIG-1:0]   an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;

    logic               slot_end;
    logic               scan_end;
    logic               drive;
    logic [3:0]         cur_digit;
    logic [6:0]         dec_seg;
    logic [N_DIG-1:0]   lz_mask;
    logic               lz_zero;

    // Slot timing and snapshot capture
    always_comb begin
        slot_end = (cnt_q == CNT_LAST);
        scan_end = slot_end && (idx_q == IDX_LAST);

        cnt_d = slot_end ? '0 : cnt_q + 1'b1;

        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // Capture on the first edge out of reset so the display does not
        // sit on zeros for a whole scan, then once per scan wrap.
        first_d = 1'b0;
        snap_d  = snap_q;
        dpm_d   = dpm_q;
        if (first_q || scan_end) begin
            snap_d = din;
            dpm_d  = dp_mask;
        end
    end

    // A digit above 0 is a leading zero when it and every higher digit are 0.
    always_comb begin
        lz_zero = 1'b1;
        lz_mask = '0;
        for (int i = N_DIG - 1; i >= 0; i--) begin
            lz_zero    = lz_zero && (snap_q[4*i +: 4] == 4'h0);
            lz_mask[i] = lz_zero && (i != 0);
        end
    end

    assign cur_digit = snap_q[4*idx_q +: 4];

    seg7_decoder u_dec (
        .bcd      (cur_digit),
        .seg_code (dec_seg)
    );

    // Output stage: registered from the current (cnt, idx) state
    always_comb begin
        drive = (cnt_q >= BLANK_V);
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (drive) begin
            if (lamp_test) begin
                an_d[idx_q] = 1'b0;
                seg_d       = SEG_ALL;
                dp_d        = 1'b0;
            end else if (!(lz_blank && lz_mask[idx_q])) begin
                an_d[idx_q] = 1'b0;
                seg_d       = dec_seg;
                dp_d        = ~dpm_q[idx_q];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            dpm_q   <= '0;
            first_q <= 1'b1;
            an_q    <= '1;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            dpm_q   <= dpm_d;
            first_q <= first_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Directed and randomized stimulus for seg7_scan_driver with N_DIG=4,
//   REFRESH_DIV=8, BLANK_CYC=2. Expected outputs come from a cycle-count
//   reference: after k clock edges since reset release the internal slot
//   position is k mod 8 and the digit is (k/8) mod 4; outputs lag that by
//   one edge. The snapshot is refreshed at edge 1 and every 32nd edge.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int SCAN = ND * RD;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   din;
    logic [3:0]    dp_mask;
    logic          lz_blank;
    logic          lamp_test;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;

    seg7_scan_driver #(.N_DIG(ND), .REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .dp_mask   (dp_mask),
        .lz_blank  (lz_blank),
        .lamp_test (lamp_test),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tbl [16];

    int          total = 0;
    int          fails = 0;
    int          k     = 0;
    logic [15:0] m_snap;
    logic [3:0]  m_dpm;
    logic [3:0]  low_seen;

    task automatic chk_an(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: an observed %b expected %b (k=%0d)", tag, got, exp, k);
        end
    endtask

    task automatic chk_seg(input string tag, input logic [6:0] got, input logic [6:0] exp);
        total++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: seg observed %h expected %h (k=%0d)", tag, got, exp, k);
        end
    endtask

    task automatic chk_dp(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: dp observed %b expected %b (k=%0d)", tag, got, exp, k);
        end
    endtask

    // One clock edge, then compare against the reference model.
    task automatic step(input string tag);
        int         pos, cslot, didx;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        @(posedge clk);
        k++;
        #1;
        pos   = (k - 1) % SCAN;
        cslot = pos % RD;
        didx  = pos / RD;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        if (cslot >= BC) begin
            if (lamp_test) begin
                e_an  = ~(4'b1 << didx);
                e_seg = 7'h00;
                e_dp  = 1'b0;
            end else if (!(lz_blank && didx > 0 && (m_snap >> (4 * didx)) == 16'h0)) begin
                e_an  = ~(4'b1 << didx);
                e_seg = seg_tbl[(m_snap >> (4 * didx)) & 16'hF];
                e_dp  = ~m_dpm[didx];
            end
        end
        chk_an(tag, an, e_an);
        chk_seg(tag, seg, e_seg);
        chk_dp(tag, dp, e_dp);
        total++;
        assert ($countones(~an) <= 1) else begin
            fails++;
            $error("FAIL %s_onehot: an observed %b expected at most one low", tag, an);
        end
        low_seen = low_seen | ~an;
        if (k == 1 || (k % SCAN) == 0) begin
            m_snap = din;
            m_dpm  = dp_mask;
        end
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic model_reset();
        k      = 0;
        m_snap = 16'h0;
        m_dpm  = 4'h0;
    endtask

    initial begin
        seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        rst       = 1'b1;
        din       = 16'h1234;
        dp_mask   = 4'h0;
        lz_blank  = 1'b0;
        lamp_test = 1'b0;
        low_seen  = 4'h0;
        model_reset();

        // Reset state
        @(posedge clk);
        #1;
        chk_an("reset", an, 4'hF);
        chk_seg("reset", seg, 7'h7F);
        chk_dp("reset", dp, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Plain scan of 1234
        run("scan1234", 2 * SCAN + 12);

        // Async reset mid-drive, checked with no clock edge in between
        rst = 1'b1;
        #1;
        chk_an("async_rst", an, 4'hF);
        chk_seg("async_rst", seg, 7'h7F);
        chk_dp("async_rst", dp, 1'b1);
        #1;
        rst = 1'b0;
        model_reset();
        run("post_rst", SCAN + 4);

        // Change din while digit 1 is being shown
        while ((k % SCAN) != 12) step("to_mid");
        din = 16'h5678;
        run("tearfree", 2 * SCAN);

        // Leading-zero suppression
        lz_blank = 1'b1;
        din      = 16'h0050;
        run("lz_settle", SCAN);
        low_seen = 4'h0;
        run("lz0050", SCAN);
        chk_an("lz0050_lit", ~low_seen, 4'b1100);
        din = 16'h0000;
        run("lz_settle0", SCAN);
        low_seen = 4'h0;
        run("lz0000", SCAN);
        chk_an("lz0000_lit", ~low_seen, 4'b1110);

        // Non-BCD digits and decimal point
        lz_blank = 1'b0;
        din      = 16'h00AF;
        dp_mask  = 4'b0100;
        run("dash_dp", 2 * SCAN);

        // Lamp test, then release mid-drive
        lamp_test = 1'b1;
        run("lamp", SCAN + 5);
        lamp_test = 1'b0;
        run("lamp_off", SCAN);

        // Randomized traffic
        for (int r = 0; r < 40; r++) begin
            din       = 16'($urandom);
            dp_mask   = 4'($urandom);
            lz_blank  = 1'($urandom);
            lamp_test = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin
                din[15:8] = 8'h00;
            end
            run("rand", $urandom_range(1, 40));
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation observed no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
